// File: rtl/pixel_op_pkg.sv
// Shared op codes and the luma helper for the RGB point-operation engine.
package pixel_op_pkg;

  localparam logic [2:0] OP_BRI_INC = 3'b000;
  localparam logic [2:0] OP_BRI_DEC = 3'b001;
  localparam logic [2:0] OP_GRAY    = 3'b010;
  localparam logic [2:0] OP_KEEP_R  = 3'b011;
  localparam logic [2:0] OP_KEEP_G  = 3'b100;
  localparam logic [2:0] OP_KEEP_B  = 3'b101;
  localparam logic [2:0] OP_THRESH  = 3'b110;
  localparam logic [2:0] OP_INVERT  = 3'b111;

  localparam int MAX_PIX_W = 16;
  // Wide enough for R + 2G + B at the largest channel width, so no overflow for any PIX_W.
  localparam int GRAY_W    = MAX_PIX_W + 2;

  function automatic logic [GRAY_W-1:0] gray_calc(input logic [GRAY_W-1:0] r,
                                                  input logic [GRAY_W-1:0] g,
                                                  input logic [GRAY_W-1:0] b);
    logic [GRAY_W-1:0] sum;
    sum = r + (g << 1) + b;
    return sum >> 2;
  endfunction

endpackage

// File: rtl/pixel_op_alu.sv
// Combinational stage-2 operation for one colour channel; CH_IDX selects which
// keep-channel op code passes this channel through.
module pixel_op_alu
  import pixel_op_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int CH_IDX = 0
) (
  input  logic [2:0]        i_op,
  input  logic [PIX_W-1:0]  i_value,
  input  logic [PIX_W-1:0]  i_ch,
  input  logic [GRAY_W-1:0] i_gray,
  output logic [PIX_W-1:0]  o_ch
);

  localparam logic [PIX_W-1:0] MAX = '1;
  localparam logic [2:0] KEEP_CODE = (CH_IDX == 0) ? OP_KEEP_R :
                                     (CH_IDX == 1) ? OP_KEEP_G : OP_KEEP_B;

  logic [PIX_W:0] w_sum;
  logic           w_thr_hit;

  assign w_sum     = {1'b0, i_ch} + {1'b0, i_value};
  assign w_thr_hit = (i_gray >= GRAY_W'(i_value));

  always_comb begin
    o_ch = '0;
    case (i_op)
      OP_BRI_INC: o_ch = w_sum[PIX_W] ? MAX : w_sum[PIX_W-1:0];
      OP_BRI_DEC: o_ch = (i_ch >= i_value) ? (i_ch - i_value) : '0;
      OP_GRAY:    o_ch = i_gray[PIX_W-1:0];
      OP_KEEP_R,
      OP_KEEP_G,
      OP_KEEP_B:  o_ch = (i_op == KEEP_CODE) ? i_ch : '0;
      OP_THRESH:  o_ch = w_thr_hit ? MAX : '0;
      OP_INVERT:  o_ch = MAX - i_ch;
      default:    o_ch = '0;
    endcase
  end

endmodule

// File: rtl/pixel_point_op.sv
// Two-stage RGB point-operation pipeline with valid/ready backpressure,
// frame-end tracking and an output pixel counter.
module pixel_point_op
  import pixel_op_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_last,
  input  logic [2:0]       operation,
  input  logic [PIX_W-1:0] value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b,
  output logic             out_last,
  output logic [CNT_W-1:0] pix_count,
  output logic             frame_done
);

  // Handshake: a beat moves when valid && ready on the same edge. A stage advances
  // when it is empty or the stage after it advances, so bubbles collapse and the
  // output holds still while out_valid && !out_ready.
  logic w_adv1;
  logic w_adv2;

  logic              r_v1;
  logic [PIX_W-1:0]  r_s1_r, r_s1_g, r_s1_b;
  logic [2:0]        r_s1_op;
  logic [PIX_W-1:0]  r_s1_value;
  logic              r_s1_last;
  logic [GRAY_W-1:0] r_s1_gray;

  logic              r_v2;
  logic [PIX_W-1:0]  r_out_r, r_out_g, r_out_b;
  logic              r_out_last;
  logic [CNT_W-1:0]  r_pix_count;
  logic              r_frame_done;

  logic [PIX_W-1:0]  w_alu_r, w_alu_g, w_alu_b;
  logic [GRAY_W-1:0] w_gray;

  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  assign w_gray = gray_calc(GRAY_W'(in_r), GRAY_W'(in_g), GRAY_W'(in_b));

  always_ff @(posedge clka) begin
    if (reset) begin
      r_v1       <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_value <= '0;
      r_s1_last  <= 1'b0;
      r_s1_gray  <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_r     <= in_r;
        r_s1_g     <= in_g;
        r_s1_b     <= in_b;
        r_s1_op    <= operation;
        r_s1_value <= value;
        r_s1_last  <= in_last;
        r_s1_gray  <= w_gray;
      end
    end
  end

  pixel_op_alu #(.PIX_W(PIX_W), .CH_IDX(0)) u_alu_r (
    .i_op(r_s1_op), .i_value(r_s1_value), .i_ch(r_s1_r), .i_gray(r_s1_gray), .o_ch(w_alu_r)
  );
  pixel_op_alu #(.PIX_W(PIX_W), .CH_IDX(1)) u_alu_g (
    .i_op(r_s1_op), .i_value(r_s1_value), .i_ch(r_s1_g), .i_gray(r_s1_gray), .o_ch(w_alu_g)
  );
  pixel_op_alu #(.PIX_W(PIX_W), .CH_IDX(2)) u_alu_b (
    .i_op(r_s1_op), .i_value(r_s1_value), .i_ch(r_s1_b), .i_gray(r_s1_gray), .o_ch(w_alu_b)
  );

  always_ff @(posedge clka) begin
    if (reset) begin
      r_v2       <= 1'b0;
      r_out_r    <= '0;
      r_out_g    <= '0;
      r_out_b    <= '0;
      r_out_last <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out_r    <= w_alu_r;
        r_out_g    <= w_alu_g;
        r_out_b    <= w_alu_b;
        r_out_last <= r_s1_last;
      end
    end
  end

  // Counter restarts at the frame's last beat; it wraps naturally at full scale.
  always_ff @(posedge clka) begin
    if (reset) begin
      r_pix_count  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_v2 && out_ready) begin
        if (r_out_last) begin
          r_pix_count  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_pix_count <= r_pix_count + 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_v2;
  assign out_r      = r_out_r;
  assign out_g      = r_out_g;
  assign out_b      = r_out_b;
  assign out_last   = r_out_last;
  assign pix_count  = r_pix_count;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_point_op.sv
// Directed bench for pixel_point_op at PIX_W=8: per-op vectors, a stalled stream,
// reset with a full pipeline, and a four-pixel frame.
module tb_pixel_point_op;

  localparam int PIX_W = 8;
  localparam int CNT_W = 20;

  logic             clka = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic             in_last = 1'b0;
  logic [2:0]       operation = 3'd0;
  logic [PIX_W-1:0] value = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_r, out_g, out_b;
  logic             out_last;
  logic [CNT_W-1:0] pix_count;
  logic             frame_done;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];

  int exp_ov[7]   = '{0, 1, 1, 1, 1, 0, 0};
  int exp_pc[7]   = '{0, 0, 1, 2, 3, 0, 0};
  int exp_fd[7]   = '{0, 0, 0, 0, 0, 1, 0};
  int exp_last[7] = '{0, 0, 0, 0, 1, 0, 0};

  pixel_point_op #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clka(clka), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
    .operation(operation), .value(value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_last(out_last),
    .pix_count(pix_count), .frame_done(frame_done)
  );

  // clock / reset
  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Send one pixel into an empty pipeline and check the result two edges later.
  task automatic send_one(input string tag, input logic [2:0] op, input logic [7:0] v,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic last,
                          input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    operation = op;
    value     = v;
    in_r      = r;
    in_g      = g;
    in_b      = b;
    in_last   = last;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk({tag, "_not_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_rgb"}, {8'd0, out_r, out_g, out_b}, {8'd0, er, eg, eb});
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    tick();
  endtask

  initial begin : main
    int sent, rcv, occ, cyc;
    logic in_hs, out_hs, stalled;
    logic [23:0] held, exp_pix;
    logic [7:0] sr, sg, sb;

    // reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // single-pixel op vectors
    send_one("bri_inc", 3'b000, 8'd50, 8'd230, 8'd10, 8'd255, 1'b1, 8'd255, 8'd60, 8'd255);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    chk("t1_pix_count", 32'(pix_count), 32'd0);
    send_one("bri_dec", 3'b001, 8'd20, 8'd10, 8'd100, 8'd20, 1'b0, 8'd0, 8'd80, 8'd0);
    chk("t2_frame_done_once", 32'(frame_done), 32'd0);
    send_one("invert", 3'b111, 8'd0, 8'd0, 8'd128, 8'd255, 1'b0, 8'd255, 8'd127, 8'd0);
    send_one("gray", 3'b010, 8'd0, 8'd100, 8'd200, 8'd40, 1'b0, 8'd135, 8'd135, 8'd135);
    send_one("thr_135", 3'b110, 8'd135, 8'd100, 8'd200, 8'd40, 1'b0, 8'd255, 8'd255, 8'd255);
    send_one("thr_136", 3'b110, 8'd136, 8'd100, 8'd200, 8'd40, 1'b0, 8'd0, 8'd0, 8'd0);
    send_one("keep_r", 3'b011, 8'd0, 8'd11, 8'd22, 8'd33, 1'b0, 8'd11, 8'd0, 8'd0);
    send_one("keep_g", 3'b100, 8'd0, 8'd11, 8'd22, 8'd33, 1'b0, 8'd0, 8'd22, 8'd0);
    send_one("keep_b", 3'b101, 8'd0, 8'd11, 8'd22, 8'd33, 1'b0, 8'd0, 8'd0, 8'd33);
    chk("pix_count_after_8", 32'(pix_count), 32'd8);

    // 16-pixel invert stream with random output stalls
    sent = 0;
    rcv = 0;
    occ = 0;
    stalled = 1'b0;
    held = '0;
    operation = 3'b111;
    value = 8'd0;
    for (cyc = 0; cyc < 300 && rcv < 16; cyc++) begin
      if (stalled) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_data_held", {8'd0, out_r, out_g, out_b}, {8'd0, held});
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 16);
      sr = 8'(sent * 13 + 7);
      sg = 8'(sent * 5);
      sb = 8'(255 - sent * 3);
      in_r = sr;
      in_g = sg;
      in_b = sb;
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'((occ == 2 && !out_ready) ? 0 : 1));
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_pix = exp_q.pop_front();
          chk("stream_data", {8'd0, out_r, out_g, out_b}, {8'd0, exp_pix});
          rcv++;
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_r, out_g, out_b};
      if (in_hs) begin
        exp_q.push_back({8'd255 - sr, 8'd255 - sg, 8'd255 - sb});
        sent++;
      end
      occ = occ + int'(in_hs) - int'(out_hs);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_received", 32'(rcv), 32'd16);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("pix_count_after_24", 32'(pix_count), 32'd24);

    // reset with both stages full
    out_ready = 1'b0;
    operation = 3'b000;
    value = 8'd1;
    in_r = 8'd90;
    in_g = 8'd91;
    in_b = 8'd92;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_pix_count", 32'(pix_count), 32'd0);
    chk("midrst_out_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // four-pixel frame, last on the fourth
    operation = 3'b000;
    value = 8'd10;
    begin : frame
      int pulses;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
        in_valid = (k < 4);
        in_r = 8'(k);
        in_g = 8'(k);
        in_b = 8'(k);
        in_last = (k == 3);
        tick();
        chk("frame_out_valid", 32'(out_valid), 32'(exp_ov[k]));
        chk("frame_pix_count", 32'(pix_count), 32'(exp_pc[k]));
        chk("frame_done_cyc", 32'(frame_done), 32'(exp_fd[k]));
        if (exp_ov[k] == 1) begin
          chk("frame_out_r", 32'(out_r), 32'(k - 1 + 10));
          chk("frame_out_last", 32'(out_last), 32'(exp_last[k]));
        end
        if (frame_done) pulses++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("frame_done_pulses", 32'(pulses), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
